// File: rtl/lzc_seq.sv
// ---------------------------------------------------------------------------
// lzc_seq -- sequential leading-zero counter
//
// Accepts one WIDTH-bit word, then scans it CHUNK bits per clock starting at
// the most significant chunk. The first nonzero chunk fixes the result:
//   o_cnt = chunk_index * CHUNK + leading zeros inside that chunk.
// An all-zero word produces o_cnt = WIDTH and o_zero = 1.
//
// Build option:
//   LZC_SEQ_EARLY_EXIT_EN  defined   -> leave SCAN as soon as the first nonzero
//                                       chunk is seen (data-dependent latency)
//                          undefined -> always scan all NCHUNK chunks
//                                       (fixed latency of NCHUNK+1 cycles)
//   The reported o_cnt / o_zero values are the same in both builds.
//
// Ports:
//   clk          in   clock, all state updates on the rising edge
//   rst          in   synchronous active-high reset, beats every handshake
//   i_valid      in   input word valid
//   o_ready      out  block is IDLE and can take a word
//   i_data       in   [WIDTH-1:0] word to scan
//   o_valid      out  result valid (state DONE)
//   i_ready      in   downstream takes the result
//   o_cnt        out  [$clog2(WIDTH):0] leading-zero count, 0..WIDTH
//   o_zero       out  captured word was all zeros
//   o_dbg_state  out  [1:0] current FSM state (0 IDLE, 1 SCAN, 2 DONE)
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid and ready are both high. o_valid, once high, stays high with o_cnt and
// o_zero unchanged until that transfer. o_ready depends only on the FSM state,
// never on i_valid, and is low from acceptance until the cycle after the
// result transfer, so a word is never accepted in the same cycle a result
// leaves.
// ---------------------------------------------------------------------------
module lzc_seq #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [WIDTH-1:0]         i_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [$clog2(WIDTH):0]   o_cnt,
  output logic                     o_zero,
  output logic [1:0]               o_dbg_state
);

  localparam int NCHUNK   = WIDTH / CHUNK;
  localparam int IW       = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CW       = $clog2(CHUNK) + 1;
  localparam int CNTW     = $clog2(WIDTH) + 1;
  localparam int CSH      = $clog2(CHUNK);
  localparam logic [IW-1:0]   LAST_IDX  = IW'(NCHUNK - 1);
  localparam logic [CNTW-1:0] ALL_ZERO  = CNTW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [WIDTH-1:0]  data_q,  data_d;
  logic [IW-1:0]     idx_q,   idx_d;
  logic [CNTW-1:0]   cnt_q,   cnt_d;
  logic              zero_q,  zero_d;
  // Set once the first nonzero chunk has been latched; blocks later chunks
  // from overwriting the result when the full scan continues.
  logic              found_q, found_d;

  // -------------------------------------------------------------------------
  // Chunk selection: chunk 0 is the most significant CHUNK bits.
  // -------------------------------------------------------------------------
  logic [CHUNK-1:0]  chunks [NCHUNK];
  logic [CHUNK-1:0]  cur_chunk;
  logic [CW-1:0]     cur_lzc;
  logic              cur_nz;
  logic              cur_last;
  logic [CNTW-1:0]   cand_cnt;

  always_comb begin
    for (int c = 0; c < NCHUNK; c++) begin
      chunks[c] = data_q[WIDTH-1-c*CHUNK -: CHUNK];
    end
  end

  // Leading-zero count of one chunk; CHUNK when the chunk is all zeros.
  function automatic logic [CW-1:0] chunk_lzc(input logic [CHUNK-1:0] c);
    logic [CW-1:0] n;
    logic          hit;
    n   = CW'(CHUNK);
    hit = 1'b0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (!hit && c[i]) begin
        n   = CW'(CHUNK - 1 - i);
        hit = 1'b1;
      end
    end
    return n;
  endfunction

  always_comb begin
    cur_chunk = chunks[idx_q];
    cur_lzc   = chunk_lzc(cur_chunk);
    cur_nz    = |cur_chunk;
    cur_last  = (idx_q == LAST_IDX);
    // CHUNK is a power of two, so idx*CHUNK is a plain shift.
    cand_cnt  = (CNTW'(idx_q) << CSH) + CNTW'(cur_lzc);
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath update
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    found_d = found_q;

    case (state_q)
      S_IDLE: begin
        // o_ready is high in IDLE, so i_valid alone completes the handshake.
        if (i_valid) begin
          data_d  = i_data;
          idx_d   = '0;
          cnt_d   = '0;
          zero_d  = 1'b0;
          found_d = 1'b0;
          state_d = S_SCAN;
        end
      end

      S_SCAN: begin
        if (!found_q && cur_nz) begin
          cnt_d   = cand_cnt;
          zero_d  = 1'b0;
          found_d = 1'b1;
        end else if (!found_q && cur_last) begin
          cnt_d   = ALL_ZERO;
          zero_d  = 1'b1;
        end

        // idx stops at the last chunk; it never wraps.
        if (!cur_last) begin
          idx_d = idx_q + IW'(1);
        end

`ifdef LZC_SEQ_EARLY_EXIT_EN
        if (cur_nz || cur_last) begin
          state_d = S_DONE;
        end
`else
        if (cur_last) begin
          state_d = S_DONE;
        end
`endif
      end

      S_DONE: begin
        if (i_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      found_q <= found_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign o_ready     = (state_q == S_IDLE);
  assign o_valid     = (state_q == S_DONE);
  assign o_cnt       = cnt_q;
  assign o_zero      = zero_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_lzc_seq.sv
// ---------------------------------------------------------------------------
// tb_lzc_seq -- self-checking bench for lzc_seq (WIDTH=64, CHUNK=8)
//
// Directed words, a stalled-output case, a mid-scan reset, then random
// back-to-back traffic. Expected counts come from a bit-by-bit reference and
// expected latencies from the acceptance-relative timing rules.
// ---------------------------------------------------------------------------
module tb_lzc_seq;

  localparam int WIDTH  = 64;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNTW   = $clog2(WIDTH) + 1;
  localparam int W      = CNTW + 1;   // scoreboard entry: {zero, cnt}

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic             clk = 1'b0;
  logic             rst;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_data;
  logic             o_valid;
  logic             i_ready;
  logic [CNTW-1:0]  o_cnt;
  logic             o_zero;
  logic [1:0]       o_dbg_state;

  always #5 clk = ~clk;

  lzc_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_data      (i_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_cnt       (o_cnt),
    .o_zero      (o_zero),
    .o_dbg_state (o_dbg_state)
  );

  int n_asserts = 0;
  int n_fail    = 0;
  logic [W-1:0] exp_q[$];

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  function automatic int ref_lzc(input logic [WIDTH-1:0] w);
    int n = 0;
    while (n < WIDTH && w[WIDTH-1-n] == 1'b0) n++;
    return n;
  endfunction

  // Cycles from acceptance (cycle T) to the first o_valid cycle.
  function automatic int ref_lat(input int n);
`ifdef LZC_SEQ_EARLY_EXIT_EN
    if (n == WIDTH) return 1 + NCHUNK;
    return 2 + n / CHUNK;
`else
    return 1 + NCHUNK;
`endif
  endfunction

  function automatic logic [W-1:0] ref_entry(input logic [WIDTH-1:0] w);
    int n;
    n = ref_lzc(w);
    return {(n == WIDTH), CNTW'(n)};
  endfunction

  function automatic logic [WIDTH-1:0] rand_word();
    logic [WIDTH-1:0] w;
    w = {$urandom(), $urandom()};
    w = w >> $urandom_range(0, WIDTH);
    return w;
  endfunction

  // -------------------------------------------------------------------------
  // Driver / checker tasks
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Send one word, wait for its result, optionally stall the output for
  // `stall` cycles while poking i_valid with new data, then take the result.
  task automatic run_word(input string tag, input logic [WIDTH-1:0] d, input int stall);
    int           w;
    int           lat;
    logic [W-1:0] e;
    logic [W-1:0] got;
    w = 0;
    while (o_ready !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    check({tag, "_ready_in"}, o_ready, 1);
    i_ready = (stall == 0);
    i_valid = 1'b1;
    i_data  = d;
    exp_q.push_back(ref_entry(d));
    tick();
    i_valid = 1'b0;
    i_data  = rand_word();
    lat = 1;
    while (o_valid !== 1'b1 && lat < 100) begin
      check({tag, "_busy_ready"}, o_ready, 0);
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, ref_lat(ref_lzc(d)));
    check({tag, "_ready_done"}, o_ready, 0);
    e   = exp_q.pop_front();
    got = {o_zero, o_cnt};
    check({tag, "_cnt"}, o_cnt, e[CNTW-1:0]);
    check({tag, "_zero"}, o_zero, e[CNTW]);
    for (int s = 0; s < stall; s++) begin
      i_valid = 1'b1;
      i_data  = rand_word();
      tick();
      check({tag, "_stall_valid"}, o_valid, 1);
      check({tag, "_stall_ready"}, o_ready, 0);
      check({tag, "_stall_hold"}, {o_zero, o_cnt}, got);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    tick();
    check({tag, "_post_valid"}, o_valid, 0);
    check({tag, "_post_ready"}, o_ready, 1);
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    rst     = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_data  = '0;
    tick();
    tick();
    check("rst_ready", o_ready, 1);
    check("rst_valid", o_valid, 0);
    check("rst_cnt", o_cnt, 0);
    check("rst_zero", o_zero, 0);
    rst = 1'b0;
    tick();

    // Directed words: MSB set, mid-word bit, LSB only, all zeros.
    run_word("msb", 64'h8000_0000_0000_0000, 0);
    run_word("bit40", 64'h0000_0100_0000_0000, 0);
    run_word("lsb", 64'h0000_0000_0000_0001, 0);
    run_word("allzero", 64'h0, 0);
    run_word("c0_mid", 64'h0F00_0000_0000_0000, 0);
    run_word("c7_top", 64'h0000_0000_0000_0080, 0);

    // Output stalled 5 cycles with new words offered meanwhile.
    run_word("stall", 64'h0000_0000_0030_0000, 5);
    run_word("after_stall", 64'h0000_0004_0000_0000, 0);

    // Reset one cycle at T+3 during a scan.
    i_valid = 1'b1;
    i_data  = 64'h0000_0000_0000_00FF;
    tick();                              // accepted; now cycle T+1
    i_valid = 1'b0;
    check("rstscan_v1", o_valid, 0);
    tick();                              // T+2
    check("rstscan_v2", o_valid, 0);
    tick();                              // T+3
    check("rstscan_v3", o_valid, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstscan_ready", o_ready, 1);
    check("rstscan_valid", o_valid, 0);
    check("rstscan_cnt", o_cnt, 0);
    check("rstscan_zero", o_zero, 0);
    for (int c = 0; c < NCHUNK + 2; c++) begin
      tick();
      check("rstscan_no_valid", o_valid, 0);
    end
    run_word("after_rst", 64'h0000_0000_0000_00FF, 0);

    // Random words one at a time.
    for (int j = 0; j < 10; j++) begin
      run_word("rand", rand_word(), $urandom_range(0, 2));
    end

    // Back-to-back: i_valid and i_ready held high throughout.
    i_valid = 1'b1;
    i_ready = 1'b1;
    for (int j = 0; j < 20; j++) begin
      logic [WIDTH-1:0] d;
      logic [W-1:0]     e;
      int               lat;
      d = rand_word();
      i_data = d;
      check("b2b_ready_in", o_ready, 1);
      exp_q.push_back(ref_entry(d));
      lat = ref_lat(ref_lzc(d));
      tick();
      i_data = rand_word();
      for (int c = 1; c < lat; c++) begin
        check("b2b_busy_valid", o_valid, 0);
        check("b2b_busy_ready", o_ready, 0);
        tick();
      end
      e = exp_q.pop_front();
      check("b2b_valid", o_valid, 1);
      check("b2b_ready_done", o_ready, 0);
      check("b2b_cnt", o_cnt, e[CNTW-1:0]);
      check("b2b_zero", o_zero, e[CNTW]);
      tick();
    end
    i_valid = 1'b0;
    tick();
    tick();
    check("b2b_end_ready", o_ready, 1);
    check("b2b_end_valid", o_valid, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lzc_seq.md
LZC_SEQ -- requirements
Module: lzc_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 64, the scanned word width; a multiple of CHUNK.
REQ-002 SHALL have parameter CHUNK, default 8, the per-cycle scan width; a power of two, at least 2. NCHUNK = WIDTH/CHUNK, at least 2.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port i_valid, input, 1 bit, input word valid.
REQ-006 SHALL have port o_ready, output, 1 bit, block can accept a word.
REQ-007 SHALL have port i_data, input, WIDTH bits, the word to scan.
REQ-008 SHALL have port o_valid, output, 1 bit, result valid.
REQ-009 SHALL have port i_ready, input, 1 bit, downstream accepts the result.
REQ-010 SHALL have port o_cnt, output, $clog2(WIDTH)+1 bits, the leading-zero count, range 0..WIDTH.
REQ-011 SHALL have port o_zero, output, 1 bit, high when the captured word was all zeros.

Function
REQ-012 SHALL implement an FSM with states IDLE, SCAN and DONE; o_ready = (state==IDLE); o_valid = (state==DONE).
REQ-013 SHALL, in IDLE when i_valid&o_ready, register i_data, clear chunk index idx to 0 and enter SCAN; i_valid SHALL be ignored in every other state.
REQ-014 SHALL evaluate exactly one chunk per SCAN cycle; chunk idx = data[WIDTH-1-idx*CHUNK -: CHUNK], so chunk 0 is the MSB chunk.
REQ-015 SHALL compute each chunk's leading-zero count combinationally as a CHUNK-wide LZC, equal to CHUNK when the chunk is all zeros.
REQ-016 SHALL, on the first nonzero chunk k, latch o_cnt = k*CHUNK + chunk_lzc and o_zero = 0; later chunks SHALL never overwrite this result.
REQ-017 SHALL, when all chunks are zero, produce o_cnt = WIDTH and o_zero = 1 after scanning chunk NCHUNK-1.
REQ-018 SHALL increment idx by 1 per SCAN cycle with no wrap; leaving SCAN SHALL occur no later than the idx==NCHUNK-1 cycle.
REQ-019 SHALL, in DONE, hold o_cnt and o_zero stable until o_valid&i_ready, then go to IDLE; o_ready SHALL rise the next cycle, so there is no same-cycle re-accept.
REQ-020 SHALL give a throughput of one word per (scan cycles + 2) when i_ready is held high.

Reset
REQ-021 SHALL, while rst is high, force state=IDLE, idx=0, o_cnt=0, o_zero=0, o_valid=0 and o_ready=1 on the next clk edge.
REQ-022 SHALL let rst asserted during SCAN or DONE discard the word in progress without producing o_valid; rst SHALL have priority over every handshake.

Configuration
REQ-023 SHALL use macro LZC_SEQ_EARLY_EXIT_EN to select early exit; defined: leave SCAN in the cycle the first nonzero chunk is found; o_valid rises at cycle T+2+k after acceptance at cycle T (k = first nonzero chunk), or at T+1+NCHUNK when the word is all zeros.
REQ-024 SHALL, with LZC_SEQ_EARLY_EXIT_EN undefined, always scan all NCHUNK chunks, so o_valid rises at T+1+NCHUNK for every word; o_cnt and o_zero values are identical in both builds.

Verification (WIDTH=64, CHUNK=8, accept at cycle T)
REQ-025 SHALL cover: i_data=0x8000_0000_0000_0000 -> o_cnt=0, o_zero=0; o_valid at T+2 with early exit, T+9 without.
REQ-026 SHALL cover: i_data=0x0000_0100_0000_0000 -> o_cnt=23; o_valid at T+4 with early exit, T+9 without.
REQ-027 SHALL cover: i_data=0x0000_0000_0000_0001 -> o_cnt=63; then i_data=0 -> o_cnt=64, o_zero=1; both with o_valid at T+9 in either build.
REQ-028 SHALL cover: i_ready held low for 5 cycles in DONE, with i_valid pulsed and new i_data -> o_cnt and o_zero stable, o_ready=0, and the new word not captured.
REQ-029 SHALL cover: rst pulsed for 1 cycle at T+3 during a scan of 0x0000_0000_0000_00FF -> no o_valid; o_ready=1, o_cnt=0 and o_zero=0 on the next cycle; the next word is processed correctly.
REQ-030 SHALL cover: back-to-back words with i_valid and i_ready always high -> o_ready is low from acceptance until the cycle after the o_valid handshake, with no dropped or duplicated results.
